piso_serial_tx: RTL and testbench

Parallel-in, serial-out frame transmitter built on async-reset, enable-gated flip-flops. It accepts a WIDTH-bit word over a valid/ready handshake and shifts it onto a single line as a frame: start bit, data bits, stop bit. Bit timing comes from an external strobe. It is the transmit end that drives the existing serial-capture register chain.

---
 rtl/piso_serial_tx_pkg.sv | 17 +
 rtl/piso_serial_tx_shift_cell.sv | 30 +++
 rtl/piso_serial_tx.sv | 117 +++++++++++
 tb/tb_piso_serial_tx.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/piso_serial_tx_pkg.sv
// Shared transmit/receive definitions: FSM state encodings and line levels.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package piso_serial_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;
    localparam logic LINE_STOP  = 1'b1;

endpackage

// File: rtl/piso_serial_tx_shift_cell.sv
// One bit of the transmit shift register: async-reset flop, loads or shifts when enabled.
// Latency: 1 clock from enable to q_o.
// Backpressure: none; holds its value whenever neither enable is set.
module piso_serial_tx_shift_cell (
    input  logic clk,
    input  logic reset_al_in,
    input  logic load_en_i,
    input  logic shift_en_i,
    input  logic par_sel_i,
    input  logic par_i,
    input  logic ser_i,
    output logic q_o
);

    logic q_q;
    logic q_d;

    assign q_d = par_sel_i ? par_i : ser_i;

    always_ff @(posedge clk or negedge reset_al_in) begin
        if (!reset_al_in) begin
            q_q <= 1'b0;
        end else if (load_en_i || shift_en_i) begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/piso_serial_tx.sv
// Parallel-in serial-out frame transmitter: start bit, WIDTH data bits, stop bit, paced by bit_en_in.
// Latency: start bit on the line 1 clock after accept; frame is WIDTH+2 bit times.
// Backpressure: ready_out low for the whole frame; sender holds data_in/valid_in until ready_out.
module piso_serial_tx
    import piso_serial_tx_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             reset_al_in,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic             ready_out,
    input  logic             bit_en_in,
    output logic             serial_out,
    output logic             busy_out,
    output logic             done_out
);

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    tx_state_e       state_q;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic            serial_q;
    logic            done_q;
    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] ser_vec;
    logic            first_bit;
    logic            next_bit;
    logic            accept;
    logic            shift_en;

    assign accept   = (state_q == ST_IDLE) && valid_in;
    assign shift_en = (state_q == ST_DATA) && bit_en_in && (cnt_q != CNT_LAST);
    assign cnt_d    = cnt_q + 1'b1;

    // The bit about to leave sits at one end; the vacated end fills with 0.
    generate
        if (MSB_FIRST) begin : g_msb
            assign ser_vec   = {sr_q[WIDTH-2:0], 1'b0};
            assign first_bit = sr_q[WIDTH-1];
            assign next_bit  = sr_q[WIDTH-2];
        end else begin : g_lsb
            assign ser_vec   = {1'b0, sr_q[WIDTH-1:1]};
            assign first_bit = sr_q[0];
            assign next_bit  = sr_q[1];
        end
    endgenerate

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        piso_serial_tx_shift_cell u_cell (
            .clk         (clk),
            .reset_al_in (reset_al_in),
            .load_en_i   (accept),
            .shift_en_i  (shift_en),
            .par_sel_i   (accept),
            .par_i       (data_in[i]),
            .ser_i       (ser_vec[i]),
            .q_o         (sr_q[i])
        );
    end

    always_ff @(posedge clk or negedge reset_al_in) begin
        if (!reset_al_in) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            serial_q <= LINE_IDLE;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (valid_in) begin
                        state_q  <= ST_START;
                        cnt_q    <= '0;
                        serial_q <= LINE_START;
                    end
                end
                ST_START: begin
                    if (bit_en_in) begin
                        state_q  <= ST_DATA;
                        serial_q <= first_bit;
                    end
                end
                ST_DATA: begin
                    if (bit_en_in) begin
                        if (cnt_q == CNT_LAST) begin
                            state_q  <= ST_STOP;
                            serial_q <= LINE_STOP;
                        end else begin
                            cnt_q    <= cnt_d;
                            serial_q <= next_bit;
                        end
                    end
                end
                ST_STOP: begin
                    if (bit_en_in) begin
                        state_q <= ST_IDLE;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready_out  = (state_q == ST_IDLE);
    assign busy_out   = (state_q != ST_IDLE);
    assign serial_out = serial_q;
    assign done_out   = done_q;

endmodule

// File: tb/tb_piso_serial_tx.sv
// Bench for piso_serial_tx: LSB-first and MSB-first instances share one stimulus stream.
module tb_piso_serial_tx;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic [W-1:0] data;
    logic         valid;
    logic         bit_en;
    logic         ready_l, ser_l, busy_l, done_l;
    logic         ready_m, ser_m, busy_m, done_m;

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    piso_serial_tx #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .reset_al_in(rst_n), .data_in(data), .valid_in(valid),
        .ready_out(ready_l), .bit_en_in(bit_en), .serial_out(ser_l),
        .busy_out(busy_l), .done_out(done_l)
    );

    piso_serial_tx #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .reset_al_in(rst_n), .data_in(data), .valid_in(valid),
        .ready_out(ready_m), .bit_en_in(bit_en), .serial_out(ser_m),
        .busy_out(busy_m), .done_out(done_m)
    );

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check10(input string name, input logic [9:0] act, input logic [9:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check32(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: position within the frame (-1 = idle, 0 = start,
    // 1..W = data bits, W+1 = stop), advanced by one per strobe.
    int           pos_q = -1;
    logic [W-1:0] word_q = '0;
    logic         m_done_q = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q    <= -1;
            m_done_q <= 1'b0;
        end else begin
            m_done_q <= 1'b0;
            if (pos_q < 0) begin
                if (valid) begin
                    pos_q  <= 0;
                    word_q <= data;
                end
            end else if (bit_en) begin
                if (pos_q == W + 1) begin
                    pos_q    <= -1;
                    m_done_q <= 1'b1;
                end else begin
                    pos_q <= pos_q + 1;
                end
            end
        end
    end

    function automatic logic exp_line(input bit msb);
        if (pos_q < 0 || pos_q == W + 1) return 1'b1;
        if (pos_q == 0) return 1'b0;
        return msb ? word_q[W - pos_q] : word_q[pos_q - 1];
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check1("mdl_ser_lsb",   ser_l,   exp_line(1'b0));
            check1("mdl_ser_msb",   ser_m,   exp_line(1'b1));
            check1("mdl_busy_lsb",  busy_l,  pos_q >= 0);
            check1("mdl_busy_msb",  busy_m,  pos_q >= 0);
            check1("mdl_ready_lsb", ready_l, pos_q < 0);
            check1("mdl_ready_msb", ready_m, pos_q < 0);
            check1("mdl_done_lsb",  done_l,  m_done_q);
            check1("mdl_done_msb",  done_m,  m_done_q);
        end
    end

    // Starts at the negedge right after an accept; samples each bit, checks it
    // holds for per clocks, strobes on the last clock of each bit.
    task automatic capture(input int per, output logic [9:0] sl, output logic [9:0] sm);
        sl = '0;
        sm = '0;
        for (int b = 0; b < 10; b++) begin
            sl[9-b] = ser_l;
            sm[9-b] = ser_m;
            for (int c = 0; c < per; c++) begin
                if (c > 0) begin
                    check1("hold_lsb", ser_l, sl[9-b]);
                    check1("hold_msb", ser_m, sm[9-b]);
                end
                bit_en = (c == per - 1);
                @(negedge clk);
            end
            bit_en = 1'b0;
        end
        check1("frame_done_lsb",  done_l,  1'b1);
        check1("frame_done_msb",  done_m,  1'b1);
        check1("frame_ready_lsb", ready_l, 1'b1);
    endtask

    task automatic run_frame(input logic [W-1:0] d, input int per,
                             output logic [9:0] sl, output logic [9:0] sm);
        valid = 1'b1;
        data  = d;
        @(negedge clk);
        valid = 1'b0;
        capture(per, sl, sm);
    endtask

    typedef struct {
        logic [W-1:0] d;
        logic [9:0]   exp_l;
        logic [9:0]   exp_m;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [9:0] sl, sm;
        int n, dones, idle, ph, early_ready;
        bit got_done, accepted, fin;

        vecs[0] = '{8'hA5, 10'b0101001011, 10'b0101001011};
        vecs[1] = '{8'h81, 10'b0100000011, 10'b0100000011};
        vecs[2] = '{8'h01, 10'b0100000001, 10'b0000000011};
        vecs[3] = '{8'h0F, 10'b0111100001, 10'b0000011111};
        vecs[4] = '{8'h3C, 10'b0001111001, 10'b0001111001};

        valid  = 1'b0;
        data   = '0;
        bit_en = 1'b0;
        #1 rst_n = 1'b0;
        chk_en = 1'b1;
        repeat (3) @(negedge clk);
        check1("rst_ser",   ser_l,   1'b1);
        check1("rst_ready", ready_l, 1'b1);
        check1("rst_busy",  busy_l,  1'b0);
        check1("rst_done",  done_m,  1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven frames, strobe every 4 clocks.
        for (int i = 0; i < 5; i++) begin
            run_frame(vecs[i].d, 4, sl, sm);
            check10("tbl_seq_lsb", sl, vecs[i].exp_l);
            check10("tbl_seq_msb", sm, vecs[i].exp_m);
        end

        // Handshake: new word offered while busy, changed before the frame ends.
        valid = 1'b1;
        data  = 8'h5A;
        @(negedge clk);
        valid = 1'b0;
        got_done = 1'b0;
        accepted = 1'b0;
        early_ready = 0;
        for (int cyc = 0; cyc < 80; cyc++) begin
            if (got_done) begin
                check1("hs_accept_busy", busy_l, 1'b1);
                check1("hs_accept_line", ser_l, 1'b0);
                accepted = 1'b1;
                break;
            end
            if (done_l) got_done = 1'b1;
            else if (ready_l) early_ready++;
            if (cyc == 3) begin
                valid = 1'b1;
                data  = 8'h3C;
            end
            if (cyc == 9) data = 8'hC3;
            bit_en = (cyc % 2 == 1);
            @(negedge clk);
        end
        valid  = 1'b0;
        bit_en = 1'b0;
        check1("hs_accepted", accepted, 1'b1);
        check32("hs_early_ready", early_ready, 0);
        capture(2, sl, sm);
        check10("hs_seq_lsb", sl, 10'b0110000111);
        check10("hs_seq_msb", sm, 10'b0110000111);

        // Continuous strobe, including on the accept edge.
        valid  = 1'b1;
        data   = 8'hFF;
        bit_en = 1'b1;
        n = 0;
        while (n < 40) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                valid = 1'b0;
                check1("strb_start", ser_l, 1'b0);
            end
            if (n == 2) check1("strb_bit0", ser_m, 1'b1);
            if (done_l) break;
        end
        check32("strb_len", n, W + 3);
        check1("strb_done_msb", done_m, 1'b1);

        // Back-to-back 8'h00 then 8'hFF with valid held.
        valid = 1'b1;
        data  = 8'h00;
        @(negedge clk);
        data  = 8'hFF;
        dones = 0;
        idle  = 0;
        ph    = 0;
        fin   = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (done_l) dones++;
            if (ph == 0) begin
                if (ready_l) begin
                    ph   = 1;
                    idle = 1;
                    check1("b2b_gap_line", ser_l, 1'b1);
                end
            end else if (ph == 1) begin
                if (ready_l) idle++;
                else begin
                    ph    = 2;
                    valid = 1'b0;
                end
            end else if (done_l) begin
                fin = 1'b1;
                break;
            end
        end
        bit_en = 1'b0;
        valid  = 1'b0;
        check1("b2b_finished", fin, 1'b1);
        check32("b2b_idle", idle, 1);
        check32("b2b_dones", dones, 2);

        // Asynchronous reset mid-DATA with the line low.
        @(negedge clk);
        valid = 1'b1;
        data  = 8'h00;
        @(negedge clk);
        valid  = 1'b0;
        bit_en = 1'b1;
        @(negedge clk);
        bit_en = 1'b0;
        @(negedge clk);
        check1("pre_rst_line", ser_l, 1'b0);
        check1("pre_rst_busy", busy_m, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        check1("arst_ser_lsb", ser_l,   1'b1);
        check1("arst_ser_msb", ser_m,   1'b1);
        check1("arst_ready",   ready_l, 1'b1);
        check1("arst_busy",    busy_m,  1'b0);
        check1("arst_done",    done_l,  1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            bit_en = k[0];
            @(negedge clk);
            check1("post_rst_line", ser_l, 1'b1);
            check1("post_rst_busy", busy_l, 1'b0);
        end
        bit_en = 1'b0;

        // Randomized traffic with occasional asynchronous resets.
        for (int k = 0; k < 3000; k++) begin
            valid  = ($urandom_range(0, 3) == 0);
            data   = 8'($urandom);
            bit_en = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 399) == 0) #1 rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
        end
        valid  = 1'b0;
        bit_en = 1'b0;
        repeat (2) @(negedge clk);
        chk_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
